lspc_vram_cpu_port: RTL and testbench

Executes CPU VRAM accesses queued by the LSPC register block: consumes the pending write request and the address, modulo and data registers, and drives the VRAM write port during CPU-granted timeline slots. It returns the write acknowledge and keeps the read-back registers prefetched at the current address. The working address auto-increments by the modulo after each write. It sits between the LSPC register block and the VRAM slot timeline/arbiter.

---
 rtl/lspc_vram_cpu_port_pkg.sv | 17 +
 rtl/lspc_vram_cpu_port_addr_step.sv | 15 +
 rtl/lspc_vram_cpu_port.sv | 157 +++++++++++++++
 tb/tb_lspc_vram_cpu_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lspc_vram_cpu_port_pkg.sv
// Shared definitions for the LSPC CPU-side VRAM access port.
//   cpu_state_t : access sequencer state encoding
//   BANK_BIT    : address bit selecting the high VRAM bank
//   LOW_AW      : width of the auto-incrementing part of the address
package lspc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,    // nothing pending
    ST_RD,      // prefetch waiting for a CPU slot
    ST_RD_CAP,  // prefetch issued, capture read data
    ST_WR       // write waiting for a CPU slot
  } cpu_state_t;

  localparam int unsigned BANK_BIT = 15;
  localparam int unsigned LOW_AW   = 15;

endpackage

// File: rtl/lspc_vram_cpu_port_addr_step.sv
// Bank-preserving modulo step for the CPU VRAM working address.
//   addr      : current working address (bit 15 = bank)
//   modulo    : increment (only the low LOW_AW bits)
//   next_addr : {bank, (addr + modulo) wrapped to LOW_AW bits}
module lspc_vram_addr_step
  import lspc_pkg::*;
(
  input  logic [15:0]       addr,
  input  logic [LOW_AW-1:0] modulo,
  output logic [15:0]       next_addr
);

  assign next_addr = {addr[BANK_BIT], addr[LOW_AW-1:0] + modulo};

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// Executes CPU VRAM accesses queued by the LSPC register block.
//   CLK, RESET              : clock, synchronous active-high reset
//   WR_VRAM_ADDR            : active-low address-register write strobe
//   REG_VRAMADDR/MOD/RW     : address, modulo, write data registers
//   nVRAM_WRITE_REQ         : active-low pending write
//   CPU_SLOT                : one-cycle CPU grant from the slot timeline
//   VRAM_LOW_DIN/HIGH_DIN   : VRAM read data
//   VRAM_ADDR/DOUT          : access address / write data (registered)
//   VRAM_LOW_WE/HIGH_WE     : bank write enables (one-cycle pulses)
//   VRAM_CPU_SEL            : CPU owns the VRAM address mux this cycle
//   VRAM_WRITE_ACK          : write done, held until request released
//   VRAM_LOW_READ/HIGH_READ : prefetched read-back data
//   BUSY                    : access pending
// All VRAM-side outputs are registered: they appear in the cycle after
// the CPU_SLOT sample.
module lspc_vram_cpu_port
  import lspc_pkg::*;
#(
  parameter int unsigned HIGH_AW = 11
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_VRAM_ADDR,
  input  logic [15:0] REG_VRAMADDR,
  input  logic [15:0] REG_VRAMMOD,
  input  logic [15:0] REG_VRAMRW,
  input  logic        nVRAM_WRITE_REQ,
  input  logic        CPU_SLOT,
  input  logic [15:0] VRAM_LOW_DIN,
  input  logic [15:0] VRAM_HIGH_DIN,
  output logic [15:0] VRAM_ADDR,
  output logic [15:0] VRAM_DOUT,
  output logic        VRAM_LOW_WE,
  output logic        VRAM_HIGH_WE,
  output logic        VRAM_CPU_SEL,
  output logic        VRAM_WRITE_ACK,
  output logic [15:0] VRAM_LOW_READ,
  output logic [15:0] VRAM_HIGH_READ,
  output logic        BUSY
);

  // High bank keeps the bank bit plus HIGH_AW address bits.
  localparam logic [15:0] HIGH_MASK =
    16'(1 << BANK_BIT) | 16'((1 << HIGH_AW) - 1);

  cpu_state_t  state, state_nx;
  logic [15:0] addr_cnt, addr_cnt_nx, addr_step, acc_addr;
  logic        wr_addr_q;
  logic        addr_load, write_det, write_pend, do_write, do_read, do_cap;

  logic [15:0] vram_addr_nx, vram_dout_nx, low_read_nx, high_read_nx;
  logic        low_we_nx, high_we_nx, sel_nx, ack_nx;

  logic        unused_mod_msb;
  assign unused_mod_msb = REG_VRAMMOD[15];

  lspc_vram_addr_step u_addr_step (
    .addr      (addr_cnt),
    .modulo    (REG_VRAMMOD[LOW_AW-1:0]),
    .next_addr (addr_step)
  );

  assign addr_load = WR_VRAM_ADDR & ~wr_addr_q;
  assign write_det = ~nVRAM_WRITE_REQ & ~VRAM_WRITE_ACK;
  // A fresh write request takes over an idle or waiting-prefetch slot
  // immediately; an in-flight capture finishes before the write.
  assign write_pend = (state == ST_WR) ||
                      (write_det && (state == ST_IDLE || state == ST_RD));
  assign do_write   = write_pend & CPU_SLOT;
  assign do_read    = (state == ST_RD) & CPU_SLOT & ~write_pend & ~addr_load;
  assign do_cap     = (state == ST_RD_CAP) & ~addr_load;
  assign acc_addr   = addr_cnt[BANK_BIT] ? (addr_cnt & HIGH_MASK) : addr_cnt;
  assign BUSY       = (state != ST_IDLE);

  always_comb begin
    state_nx     = state;
    addr_cnt_nx  = addr_cnt;
    sel_nx       = 1'b0;
    low_we_nx    = 1'b0;
    high_we_nx   = 1'b0;
    vram_addr_nx = VRAM_ADDR;
    vram_dout_nx = VRAM_DOUT;
    low_read_nx  = VRAM_LOW_READ;
    high_read_nx = VRAM_HIGH_READ;
    ack_nx       = VRAM_WRITE_ACK;

    case (state)
      ST_IDLE:   if (write_det) state_nx = ST_WR;
      ST_RD:     if (write_det) state_nx = ST_WR;
      ST_RD_CAP: state_nx = write_det ? ST_WR : ST_IDLE;
      ST_WR:     state_nx = ST_WR;
      default:   state_nx = ST_IDLE;
    endcase

    if (do_write) begin
      state_nx     = ST_RD;
      addr_cnt_nx  = addr_step;
      sel_nx       = 1'b1;
      low_we_nx    = ~addr_cnt[BANK_BIT];
      high_we_nx   = addr_cnt[BANK_BIT];
      vram_addr_nx = acc_addr;
      vram_dout_nx = REG_VRAMRW;
    end else if (do_read) begin
      state_nx     = ST_RD_CAP;
      sel_nx       = 1'b1;
      vram_addr_nx = acc_addr;
    end

    if (do_cap) begin
      if (addr_cnt[BANK_BIT]) high_read_nx = VRAM_HIGH_DIN;
      else                    low_read_nx  = VRAM_LOW_DIN;
    end

    // Address load beats the post-write increment and restarts the
    // prefetch; an unserved write stays queued on the new address.
    if (addr_load) begin
      addr_cnt_nx = REG_VRAMADDR;
      if (!do_write && (write_pend || write_det)) state_nx = ST_WR;
      else                                        state_nx = ST_RD;
    end

    if (do_write)             ack_nx = 1'b1;
    else if (nVRAM_WRITE_REQ) ack_nx = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_cnt       <= '0;
      wr_addr_q      <= 1'b1;
      VRAM_ADDR      <= '0;
      VRAM_DOUT      <= '0;
      VRAM_LOW_WE    <= 1'b0;
      VRAM_HIGH_WE   <= 1'b0;
      VRAM_CPU_SEL   <= 1'b0;
      VRAM_WRITE_ACK <= 1'b0;
      VRAM_LOW_READ  <= '0;
      VRAM_HIGH_READ <= '0;
    end else begin
      addr_cnt       <= addr_cnt_nx;
      wr_addr_q      <= WR_VRAM_ADDR;
      VRAM_ADDR      <= vram_addr_nx;
      VRAM_DOUT      <= vram_dout_nx;
      VRAM_LOW_WE    <= low_we_nx;
      VRAM_HIGH_WE   <= high_we_nx;
      VRAM_CPU_SEL   <= sel_nx;
      VRAM_WRITE_ACK <= ack_nx;
      VRAM_LOW_READ  <= low_read_nx;
      VRAM_HIGH_READ <= high_read_nx;
    end
  end

endmodule

// File: tb/tb_lspc_vram_cpu_port.sv
module tb_lspc_vram_cpu_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WR_VRAM_ADDR;
  logic [15:0] REG_VRAMADDR, REG_VRAMMOD, REG_VRAMRW;
  logic        nVRAM_WRITE_REQ;
  logic        CPU_SLOT;
  logic [15:0] VRAM_LOW_DIN, VRAM_HIGH_DIN;
  logic [15:0] VRAM_ADDR, VRAM_DOUT;
  logic        VRAM_LOW_WE, VRAM_HIGH_WE, VRAM_CPU_SEL, VRAM_WRITE_ACK;
  logic [15:0] VRAM_LOW_READ, VRAM_HIGH_READ;
  logic        BUSY;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  lspc_vram_cpu_port #(.HIGH_AW(11)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .WR_VRAM_ADDR    (WR_VRAM_ADDR),
    .REG_VRAMADDR    (REG_VRAMADDR),
    .REG_VRAMMOD     (REG_VRAMMOD),
    .REG_VRAMRW      (REG_VRAMRW),
    .nVRAM_WRITE_REQ (nVRAM_WRITE_REQ),
    .CPU_SLOT        (CPU_SLOT),
    .VRAM_LOW_DIN    (VRAM_LOW_DIN),
    .VRAM_HIGH_DIN   (VRAM_HIGH_DIN),
    .VRAM_ADDR       (VRAM_ADDR),
    .VRAM_DOUT       (VRAM_DOUT),
    .VRAM_LOW_WE     (VRAM_LOW_WE),
    .VRAM_HIGH_WE    (VRAM_HIGH_WE),
    .VRAM_CPU_SEL    (VRAM_CPU_SEL),
    .VRAM_WRITE_ACK  (VRAM_WRITE_ACK),
    .VRAM_LOW_READ   (VRAM_LOW_READ),
    .VRAM_HIGH_READ  (VRAM_HIGH_READ),
    .BUSY            (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Strobe the address register: low for a cycle, then high (load edge).
  task automatic load_addr(input logic [15:0] a);
    REG_VRAMADDR = a;
    WR_VRAM_ADDR = 1'b0;
    tick();
    WR_VRAM_ADDR = 1'b1;
    tick();
  endtask

  // Complete a pending prefetch with a slot, then the capture cycle.
  task automatic prefetch(input string tag, input logic [15:0] exp_addr);
    CPU_SLOT = 1'b1;
    tick();
    CPU_SLOT = 1'b0;
    check({tag, "_sel"}, 16'(VRAM_CPU_SEL), 16'h1);
    check({tag, "_addr"}, VRAM_ADDR, exp_addr);
    check({tag, "_we"}, 16'({VRAM_HIGH_WE, VRAM_LOW_WE}), 16'h0);
    tick();
  endtask

  logic seen;

  initial begin
    RESET = 1'b1; WR_VRAM_ADDR = 1'b1; nVRAM_WRITE_REQ = 1'b1; CPU_SLOT = 1'b0;
    REG_VRAMADDR = '0; REG_VRAMMOD = '0; REG_VRAMRW = '0;
    VRAM_LOW_DIN = '0; VRAM_HIGH_DIN = '0;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset state, then idle with slots toggling.
    check("rst_addr", VRAM_ADDR, 16'h0);
    check("rst_dout", VRAM_DOUT, 16'h0);
    check("rst_busy", 16'(BUSY), 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      CPU_SLOT = ~CPU_SLOT;
      tick();
      seen = seen | VRAM_LOW_WE | VRAM_HIGH_WE | VRAM_CPU_SEL | VRAM_WRITE_ACK;
    end
    CPU_SLOT = 1'b0;
    check("idle_activity", 16'(seen), 16'h0);
    check("idle_low_read", VRAM_LOW_READ, 16'h0);
    check("idle_high_read", VRAM_HIGH_READ, 16'h0);

    // Address load triggers a prefetch.
    load_addr(16'h7000);
    check("load_busy", 16'(BUSY), 16'h1);
    VRAM_LOW_DIN = 16'h1234;
    prefetch("pf7000", 16'h7000);
    check("pf7000_data", VRAM_LOW_READ, 16'h1234);
    check("pf7000_busy", 16'(BUSY), 16'h0);

    // Write at 0x7FFF, modulo 1: low WE, 15-bit wrap to 0x0000.
    REG_VRAMMOD = 16'h0001; REG_VRAMRW = 16'hBEEF;
    load_addr(16'h7FFF);
    nVRAM_WRITE_REQ = 1'b0; CPU_SLOT = 1'b1;
    tick();
    check("w1_low_we", 16'(VRAM_LOW_WE), 16'h1);
    check("w1_high_we", 16'(VRAM_HIGH_WE), 16'h0);
    check("w1_addr", VRAM_ADDR, 16'h7FFF);
    check("w1_dout", VRAM_DOUT, 16'hBEEF);
    check("w1_ack", 16'(VRAM_WRITE_ACK), 16'h1);
    // Request still held with slots offered: no second write, ACK holds.
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | VRAM_LOW_WE | VRAM_HIGH_WE;
    end
    CPU_SLOT = 1'b0;
    check("w1_no_rewrite", 16'(seen), 16'h0);
    check("w1_ack_held", 16'(VRAM_WRITE_ACK), 16'h1);
    nVRAM_WRITE_REQ = 1'b1;
    tick();
    check("w1_ack_clr", 16'(VRAM_WRITE_ACK), 16'h0);
    // The held slots above already prefetched the wrapped address.
    load_addr(16'h0000);
    VRAM_LOW_DIN = 16'h5555;
    prefetch("pf0000", 16'h0000);
    check("pf0000_data", VRAM_LOW_READ, 16'h5555);

    // High bank, modulo 0x20, two writes.
    REG_VRAMMOD = 16'h0020; REG_VRAMRW = 16'hA5A5;
    load_addr(16'h8010);
    nVRAM_WRITE_REQ = 1'b0; CPU_SLOT = 1'b1;
    tick();
    CPU_SLOT = 1'b0;
    check("w2_high_we", 16'(VRAM_HIGH_WE), 16'h1);
    check("w2_low_we", 16'(VRAM_LOW_WE), 16'h0);
    check("w2_addr", VRAM_ADDR, 16'h8010);
    check("w2_dout", VRAM_DOUT, 16'hA5A5);
    nVRAM_WRITE_REQ = 1'b1;
    tick();
    check("w2_ack_clr", 16'(VRAM_WRITE_ACK), 16'h0);
    REG_VRAMRW = 16'h5A5A; nVRAM_WRITE_REQ = 1'b0; CPU_SLOT = 1'b1;
    tick();
    CPU_SLOT = 1'b0;
    check("w3_high_we", 16'(VRAM_HIGH_WE), 16'h1);
    check("w3_addr", VRAM_ADDR, 16'h8030);
    check("w3_dout", VRAM_DOUT, 16'h5A5A);
    check("w3_ack", 16'(VRAM_WRITE_ACK), 16'h1);
    nVRAM_WRITE_REQ = 1'b1;
    tick();
    check("w3_ack_clr", 16'(VRAM_WRITE_ACK), 16'h0);
    VRAM_HIGH_DIN = 16'h0BAD; VRAM_LOW_DIN = 16'hFFFF;
    prefetch("pf8050", 16'h8050);
    check("pf8050_high", VRAM_HIGH_READ, 16'h0BAD);
    check("pf8050_low_kept", VRAM_LOW_READ, 16'h5555);

    // High bank uses only HIGH_AW address bits.
    load_addr(16'h9C05);
    prefetch("pf_mask", 16'h8405);

    // Address load in the same cycle as the write slot.
    load_addr(16'h0100);
    REG_VRAMADDR = 16'h0200; WR_VRAM_ADDR = 1'b0;
    tick();
    WR_VRAM_ADDR = 1'b1; REG_VRAMRW = 16'h1111;
    nVRAM_WRITE_REQ = 1'b0; CPU_SLOT = 1'b1;
    tick();
    CPU_SLOT = 1'b0; nVRAM_WRITE_REQ = 1'b1;
    check("ld_w_low_we", 16'(VRAM_LOW_WE), 16'h1);
    check("ld_w_addr", VRAM_ADDR, 16'h0100);
    check("ld_w_dout", VRAM_DOUT, 16'h1111);
    tick();
    check("ld_w_busy", 16'(BUSY), 16'h1);
    prefetch("ld_pf", 16'h0200);

    // Reset in the cycle the write slot is sampled.
    load_addr(16'h0300);
    nVRAM_WRITE_REQ = 1'b0; CPU_SLOT = 1'b1; RESET = 1'b1;
    tick();
    RESET = 1'b0; CPU_SLOT = 1'b0; nVRAM_WRITE_REQ = 1'b1;
    check("rst_mid_we", 16'({VRAM_HIGH_WE, VRAM_LOW_WE}), 16'h0);
    check("rst_mid_ack", 16'(VRAM_WRITE_ACK), 16'h0);
    check("rst_mid_busy", 16'(BUSY), 16'h0);
    check("rst_mid_sel", 16'(VRAM_CPU_SEL), 16'h0);
    tick();
    check("rst_mid_we2", 16'({VRAM_HIGH_WE, VRAM_LOW_WE}), 16'h0);
    check("rst_mid_read", VRAM_LOW_READ, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
